grf_wb_arbiter: RTL and testbench

- Shares the single general-register-file write port between NREQ write-back requesters (e.g. main pipeline WB, mult/div unit, multi-cycle load unit).
- Round-robin arbitration with a valid/ready handshake; one registered write stage drives the GRF write port (RegWr, RWAddr, WrData, WPC).
- Exposes rs/rt forwarding from the registered stage, so readers see a value granted but not yet committed.
- Keeps a saturating conflict counter for performance debug.

---
 rtl/grf_wb_arbiter_pkg.sv | 25 ++
 rtl/grf_wb_arbiter_rr_pick.sv | 31 +++
 rtl/grf_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_grf_wb_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grf_wb_arbiter_pkg.sv
// Shared CPU constants for the GRF write-back arbiter and related port arbiters.
package grf_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // Register $0 is hard-wired to zero and is never written.
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Requester indices; WB_MAIN has priority straight out of reset.
  localparam int WB_MAIN = 0;
  localparam int WB_MDU  = 1;
  localparam int WB_LSU  = 2;

  // Number of set bits in a request vector of up to four requesters.
  function automatic logic [2:0] req_popcount(input logic [3:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/grf_wb_arbiter_rr_pick.sv
// Round-robin priority picker: one-hot grant to the first set request bit,
// searching upward from the pointer and wrapping at NREQ. Purely combinational.
module grf_wb_arbiter_rr_pick #(
  parameter int NREQ  = 3,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_grant
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  // Scan from the pointer position and grant the first requester found.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = PTR_W'((int'(i_ptr) + k) % NREQ);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: round-robin grant among write-back requesters,
// one registered write stage feeding the register file, rs/rt forwarding
// from that stage, and a saturating conflict counter for perf debug.
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [REG_ADDR_W*NREQ-1:0] req_addr,
  input  logic [DATA_W*NREQ-1:0]     req_data,
  input  logic [DATA_W*NREQ-1:0]     req_pc,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       wb_hold,
  output logic                       RegWr,
  output logic [REG_ADDR_W-1:0]      RWAddr,
  output logic [DATA_W-1:0]          WrData,
  output logic [DATA_W-1:0]          WPC,
  input  logic [REG_ADDR_W-1:0]      rs,
  input  logic [REG_ADDR_W-1:0]      rt,
  output logic                       fwd_rs_hit,
  output logic [DATA_W-1:0]          fwd_rs_data,
  output logic                       fwd_rt_hit,
  output logic [DATA_W-1:0]          fwd_rt_data,
  output logic [CNT_W-1:0]           conflict_cnt
);

  localparam int PTR_W = $clog2(NREQ);

  logic                  r_wb_valid;
  logic [REG_ADDR_W-1:0] r_rw_addr;
  logic [DATA_W-1:0]     r_wr_data;
  logic [DATA_W-1:0]     r_wpc;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [CNT_W-1:0]      r_conflict_cnt;

  logic [NREQ-1:0]       w_pick;
  logic [NREQ-1:0]       w_ready;
  logic                  w_fire;
  logic [PTR_W-1:0]      w_sel_idx;
  logic [PTR_W-1:0]      w_next_ptr;
  logic [REG_ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0]     w_sel_data;
  logic [DATA_W-1:0]     w_sel_pc;
  logic [3:0]            w_valid4;
  logic                  w_multi;

  grf_wb_arbiter_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick)
  );

  // Suppress grants while hold is high or reset is asserted.
  always_comb begin
    if (wb_hold || !Reset) begin
      w_ready = '0;
    end else begin
      w_ready = w_pick;
    end
  end

  // Mux out the payload of the granted requester.
  always_comb begin
    w_fire     = 1'b0;
    w_sel_idx  = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_pc   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_ready[i] && req_valid[i]) begin
        w_fire     = 1'b1;
        w_sel_idx  = PTR_W'(i);
        w_sel_addr = req_addr[REG_ADDR_W*i +: REG_ADDR_W];
        w_sel_data = req_data[DATA_W*i +: DATA_W];
        w_sel_pc   = req_pc[DATA_W*i +: DATA_W];
      end else begin
        w_fire = w_fire;
      end
    end
  end

  // Pointer moves to the requester just after the one granted, wrapping.
  always_comb begin
    if (w_sel_idx == PTR_W'(NREQ - 1)) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = w_sel_idx + PTR_W'(1);
    end
  end

  // A conflict is two or more simultaneous requests while arbitration runs.
  always_comb begin
    w_valid4             = 4'b0000;
    w_valid4[NREQ-1:0]   = req_valid;
    w_multi              = (req_popcount(w_valid4) >= 3'd2) && !wb_hold;
  end

  // Write stage: capture the granted write; drains unconditionally each cycle.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_wb_valid <= 1'b0;
      r_rw_addr  <= '0;
      r_wr_data  <= '0;
      r_wpc      <= '0;
    end else if (w_fire) begin
      r_wb_valid <= 1'b1;
      r_rw_addr  <= w_sel_addr;
      r_wr_data  <= w_sel_data;
      r_wpc      <= w_sel_pc;
    end else begin
      r_wb_valid <= 1'b0;
    end
  end

  // Round-robin pointer advances only on a completed transfer.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_rr_ptr <= '0;
    end else if (w_fire) begin
      r_rr_ptr <= w_next_ptr;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

  // Saturating conflict counter; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_conflict_cnt <= '0;
    end else if (w_multi && (r_conflict_cnt != {CNT_W{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
    end else begin
      r_conflict_cnt <= r_conflict_cnt;
    end
  end

  assign req_ready    = w_ready;
  assign RegWr        = r_wb_valid && (r_rw_addr != REG_ZERO);
  assign RWAddr       = r_rw_addr;
  assign WrData       = r_wr_data;
  assign WPC          = r_wpc;
  assign conflict_cnt = r_conflict_cnt;

  // A write to $0 never forwards, matching the GRF's hard-wired zero.
  assign fwd_rs_hit  = r_wb_valid && (r_rw_addr == rs) && (rs != REG_ZERO);
  assign fwd_rs_data = fwd_rs_hit ? r_wr_data : {DATA_W{1'b0}};
  assign fwd_rt_hit  = r_wb_valid && (r_rw_addr == rt) && (rt != REG_ZERO);
  assign fwd_rt_data = fwd_rt_hit ? r_wr_data : {DATA_W{1'b0}};

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Self-checking bench for grf_wb_arbiter: directed scenarios followed by a
// randomized phase, all compared against a transaction-level reference model.
module tb_grf_wb_arbiter;

  localparam int NREQ = 3;

  logic        clk = 1'b0;
  logic        Reset;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [95:0] req_pc;
  logic        wb_hold;
  logic [4:0]  rs;
  logic [4:0]  rt;

  logic [2:0]  req_ready;
  logic        RegWr;
  logic [4:0]  RWAddr;
  logic [31:0] WrData;
  logic [31:0] WPC;
  logic        fwd_rs_hit;
  logic [31:0] fwd_rs_data;
  logic        fwd_rt_hit;
  logic [31:0] fwd_rt_data;
  logic [15:0] conflict_cnt;

  // Second instance with a 2-bit counter so saturation is reachable.
  logic [2:0]  s_req_ready;
  logic        s_RegWr;
  logic [4:0]  s_RWAddr;
  logic [31:0] s_WrData;
  logic [31:0] s_WPC;
  logic        s_fwd_rs_hit;
  logic [31:0] s_fwd_rs_data;
  logic        s_fwd_rt_hit;
  logic [31:0] s_fwd_rt_data;
  logic [1:0]  s_conflict_cnt;

  grf_wb_arbiter #(.NREQ(3), .CNT_W(16)) dut (
    .clk(clk), .Reset(Reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_pc(req_pc), .req_ready(req_ready),
    .wb_hold(wb_hold), .RegWr(RegWr), .RWAddr(RWAddr), .WrData(WrData),
    .WPC(WPC), .rs(rs), .rt(rt), .fwd_rs_hit(fwd_rs_hit),
    .fwd_rs_data(fwd_rs_data), .fwd_rt_hit(fwd_rt_hit),
    .fwd_rt_data(fwd_rt_data), .conflict_cnt(conflict_cnt)
  );

  grf_wb_arbiter #(.NREQ(3), .CNT_W(2)) dut_sat (
    .clk(clk), .Reset(Reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_pc(req_pc), .req_ready(s_req_ready),
    .wb_hold(wb_hold), .RegWr(s_RegWr), .RWAddr(s_RWAddr), .WrData(s_WrData),
    .WPC(s_WPC), .rs(rs), .rt(rt), .fwd_rs_hit(s_fwd_rs_hit),
    .fwd_rs_data(s_fwd_rs_data), .fwd_rt_hit(s_fwd_rt_hit),
    .fwd_rt_data(s_fwd_rt_data), .conflict_cnt(s_conflict_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the pending write and the arbitration state.
  int          m_ptr;
  bit          m_valid;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_pc;
  int          m_cnt;
  int          m_last_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    m_valid  = 1'b0;
    m_addr   = 5'd0;
    m_data   = 32'd0;
    m_pc     = 32'd0;
    m_cnt    = 0;
    m_last_g = -1;
  endtask

  task automatic drive(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                       input logic [95:0] p, input logic h, input logic [4:0] s,
                       input logic [4:0] t);
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    req_pc    = p;
    wb_hold   = h;
    rs        = s;
    rt        = t;
    #1;
  endtask

  // Compare every output with the model, then advance one clock.
  task automatic tick();
    int         g;
    int         idx;
    logic [2:0] er;
    bit         rs_hit;
    bit         rt_hit;
    g = -1;
    if (!wb_hold && Reset) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    er     = (g >= 0) ? (3'b001 << g) : 3'b000;
    rs_hit = m_valid && (m_addr == rs) && (rs != 5'd0);
    rt_hit = m_valid && (m_addr == rt) && (rt != 5'd0);
    chk("req_ready", req_ready, er);
    chk("RegWr", RegWr, m_valid && (m_addr != 5'd0));
    chk("RWAddr", RWAddr, m_addr);
    chk("WrData", WrData, m_data);
    chk("WPC", WPC, m_pc);
    chk("fwd_rs_hit", fwd_rs_hit, rs_hit);
    chk("fwd_rs_data", fwd_rs_data, rs_hit ? m_data : 32'd0);
    chk("fwd_rt_hit", fwd_rt_hit, rt_hit);
    chk("fwd_rt_data", fwd_rt_data, rt_hit ? m_data : 32'd0);
    chk("conflict_cnt", conflict_cnt, m_cnt);
    chk("sat_conflict_cnt", s_conflict_cnt, (m_cnt > 3) ? 3 : m_cnt);
    chk("sat_req_ready", s_req_ready, er);
    @(posedge clk);
    #1;
    if (g >= 0) begin
      m_valid = 1'b1;
      m_addr  = req_addr[5*g +: 5];
      m_data  = req_data[32*g +: 32];
      m_pc    = req_pc[32*g +: 32];
      m_ptr   = (g + 1) % NREQ;
    end else begin
      m_valid = 1'b0;
    end
    if ($countones(req_valid) >= 2 && !wb_hold && m_cnt < 65535) m_cnt++;
    m_last_g = g;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    drive(3'b000, 15'd0, 96'd0, 96'd0, 1'b0, 5'd0, 5'd0);
    model_reset();
    @(posedge clk);
    #1;
    Reset = 1'b1;
  endtask

  bit          pend[3];
  logic [4:0]  pa[3];
  logic [31:0] pd[3];
  logic [31:0] pp[3];

  initial begin
    int          exp_order[6];
    int          cnt_before;
    logic [2:0]  v;
    logic [14:0] a;
    logic [95:0] d;
    logic [95:0] p;
    logic [4:0]  s;
    logic [4:0]  t;

    // Reset state: everything reads zero.
    Reset = 1'b0;
    drive(3'b000, 15'd0, 96'd0, 96'd0, 1'b0, 5'd0, 5'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_ready", req_ready, 3'b000);
    chk("rst_RegWr", RegWr, 1'b0);
    chk("rst_WrData", WrData, 32'd0);
    chk("rst_WPC", WPC, 32'd0);
    chk("rst_conflict_cnt", conflict_cnt, 16'd0);
    @(posedge clk);
    #1;
    Reset = 1'b1;

    // Single request from requester 0, one-cycle write latency.
    drive(3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'h1234},
          {32'd0, 32'd0, 32'h3000}, 1'b0, 5'd0, 5'd0);
    chk("t1_ready", req_ready, 3'b001);
    tick();
    chk("t1_RegWr", RegWr, 1'b1);
    chk("t1_RWAddr", RWAddr, 5'd5);
    chk("t1_WrData", WrData, 32'h1234);
    chk("t1_WPC", WPC, 32'h3000);

    // All three requesting continuously: strict rotation from a fresh reset.
    do_reset();
    exp_order = '{0, 1, 2, 0, 1, 2};
    for (int i = 0; i < 6; i++) begin
      drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA},
            {32'h300C, 32'h300B, 32'h300A}, 1'b0, 5'd1, 5'd2);
      chk("t2_rr_order", req_ready, 3'b001 << exp_order[i]);
      tick();
    end
    chk("t2_conflict_cnt", conflict_cnt, 16'd6);
    chk("t2_sat_cnt", s_conflict_cnt, 2'd3);

    // Write to $0: handshake completes but no GRF write, no forwarding.
    drive(3'b010, {5'd0, 5'd0, 5'd0}, {32'd0, 32'hFFFF, 32'd0},
          {32'd0, 32'h4000, 32'd0}, 1'b0, 5'd0, 5'd0);
    chk("t3_ready", req_ready, 3'b010);
    tick();
    drive(3'b000, 15'd0, 96'd0, 96'd0, 1'b0, 5'd0, 5'd0);
    chk("t3_RegWr", RegWr, 1'b0);
    chk("t3_fwd_rs_hit", fwd_rs_hit, 1'b0);
    tick();

    // Forwarding from the pending stage, gone once the stage drains.
    drive(3'b001, {5'd0, 5'd0, 5'd9}, {32'd0, 32'd0, 32'hBEEF},
          {32'd0, 32'd0, 32'h5000}, 1'b0, 5'd0, 5'd0);
    tick();
    drive(3'b000, 15'd0, 96'd0, 96'd0, 1'b0, 5'd9, 5'd9);
    chk("t4_rs_hit", fwd_rs_hit, 1'b1);
    chk("t4_rt_hit", fwd_rt_hit, 1'b1);
    chk("t4_rs_data", fwd_rs_data, 32'hBEEF);
    chk("t4_rt_data", fwd_rt_data, 32'hBEEF);
    tick();
    drive(3'b000, 15'd0, 96'd0, 96'd0, 1'b0, 5'd9, 5'd9);
    chk("t4_rs_hit_idle", fwd_rs_hit, 1'b0);
    chk("t4_rt_data_idle", fwd_rt_data, 32'd0);
    tick();

    // Hold: staged write still commits, no grants, counter frozen.
    drive(3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'h77, 32'd0},
          {32'd0, 32'h6000, 32'd0}, 1'b0, 5'd0, 5'd0);
    tick();
    cnt_before = m_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(3'b101, {5'd4, 5'd0, 5'd8}, {32'h44, 32'd0, 32'h88},
            {32'h7004, 32'd0, 32'h7008}, 1'b1, 5'd7, 5'd0);
      chk("t5_hold_ready", req_ready, 3'b000);
      chk("t5_hold_RegWr", RegWr, (i == 0) ? 1'b1 : 1'b0);
      tick();
    end
    chk("t5_hold_cnt", conflict_cnt, cnt_before[15:0]);
    drive(3'b101, {5'd4, 5'd0, 5'd8}, {32'h44, 32'd0, 32'h88},
          {32'h7004, 32'd0, 32'h7008}, 1'b0, 5'd0, 5'd0);
    chk("t5_release_ready", req_ready, 3'b100);
    tick();

    // Asynchronous reset between edges with a write staged.
    drive(3'b010, {5'd0, 5'd12, 5'd0}, {32'd0, 32'hC0DE, 32'd0},
          {32'd0, 32'h8000, 32'd0}, 1'b0, 5'd0, 5'd0);
    tick();
    chk("t6_staged_RegWr", RegWr, 1'b1);
    drive(3'b000, 15'd0, 96'd0, 96'd0, 1'b0, 5'd0, 5'd0);
    #1;
    Reset = 1'b0;
    #1;
    chk("t6_async_RegWr", RegWr, 1'b0);
    chk("t6_async_WrData", WrData, 32'd0);
    chk("t6_async_cnt", conflict_cnt, 16'd0);
    model_reset();
    @(posedge clk);
    #1;
    Reset = 1'b1;
    drive(3'b110, {5'd6, 5'd5, 5'd0}, {32'h66, 32'h55, 32'd0},
          {32'h9006, 32'h9005, 32'd0}, 1'b0, 5'd0, 5'd0);
    chk("t6_first_grant", req_ready, 3'b010);
    tick();

    // Randomized phase: requesters keep valid and payload until granted.
    for (int i = 0; i < 3; i++) pend[i] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
          pend[i] = 1'b1;
          pa[i]   = 5'($urandom_range(0, 31));
          pd[i]   = $urandom;
          pp[i]   = $urandom;
        end
      end
      v = 3'b000;
      a = 15'd0;
      d = 96'd0;
      p = 96'd0;
      for (int i = 0; i < 3; i++) begin
        v[i]          = pend[i];
        a[5*i +: 5]   = pend[i] ? pa[i] : 5'($urandom_range(0, 31));
        d[32*i +: 32] = pend[i] ? pd[i] : $urandom;
        p[32*i +: 32] = pend[i] ? pp[i] : $urandom;
      end
      s = ($urandom_range(0, 1) == 0) ? m_addr : 5'($urandom_range(0, 31));
      t = ($urandom_range(0, 1) == 0) ? m_addr : 5'($urandom_range(0, 31));
      drive(v, a, d, p, ($urandom_range(0, 5) == 0), s, t);
      tick();
      if (m_last_g >= 0) pend[m_last_g] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
